// File: rtl/cache_control_nway_if.sv
// Bundle of every datapath / CPU / pmem signal seen by the N-way cache controller.
// The master modport is the controller; the slave modport is the surrounding datapath and memory.
interface cache_control_nway_if #(
  parameter int WAYS      = 4,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 32
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic              mem_read;
  logic              mem_write;
  logic              mem_resp;
  logic [WAYS-1:0]   hit_way;
  logic [WAYS-1:0]   valid_way;
  logic [WAYS-1:0]   dirty_way;
  logic [WAY_W-1:0]  plru_victim;
  logic              pmem_read;
  logic              pmem_write;
  logic              pmem_single;
  logic              pmem_resp;
  logic [BEAT_W-1:0] pmem_beat;
  logic [WAY_W-1:0]  way_sel;
  logic              addr_sel;
  logic [WAYS-1:0]   load_data;
  logic [WAYS-1:0]   load_tag;
  logic [WAYS-1:0]   load_valid;
  logic [WAYS-1:0]   load_dirty;
  logic              dirty_in;
  logic              load_plru;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;
  logic              multi_hit_err;

  modport master (
    input  mem_read, mem_write, hit_way, valid_way, dirty_way, plru_victim, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_single, pmem_beat, way_sel, addr_sel,
           load_data, load_tag, load_valid, load_dirty, dirty_in, load_plru,
           hit_count, miss_count, multi_hit_err
  );

  modport slave (
    output mem_read, mem_write, hit_way, valid_way, dirty_way, plru_victim, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_single, pmem_beat, way_sel, addr_sel,
           load_data, load_tag, load_valid, load_dirty, dirty_in, load_plru,
           hit_count, miss_count, multi_hit_err
  );
endinterface

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative write-back cache with burst fill/evict.
//   state          | meaning
//   S_IDLE         | waiting for exactly one of mem_read / mem_write
//   S_HIT_CHECK    | tag compare result available; respond on hit, pick victim on miss
//   S_WRITE_BACK   | bursting the dirty victim line out to pmem
//   S_ALLOCATE     | bursting the requested line in from pmem into the victim way
//   S_WRITE_AROUND | single-word write straight to pmem (no-write-allocate mode)
// Outputs are decoded from the registered state, so IDLE (and reset) drives all of them to 0.
module cache_control_nway #(
  parameter int WAYS           = 4,
  parameter int BURST_LEN      = 4,
  parameter int WRITE_ALLOCATE = 1,
  parameter int CNT_W          = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  cache_control_nway_if.master io_bus
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [WAYS-1:0]   ONE_HOT0  = WAYS'(1);
  localparam bit NO_ALLOC = (WRITE_ALLOCATE == 0);

  typedef enum logic [2:0] {
    S_IDLE, S_HIT_CHECK, S_WRITE_BACK, S_ALLOCATE, S_WRITE_AROUND
  } state_t;

  state_t            r_state;
  logic [BEAT_W-1:0] r_beat;
  logic [WAY_W-1:0]  r_victim;
  logic              r_refill;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;
  logic              r_multi_err;

  logic              w_req;
  logic              w_hit;
  logic              w_multi;
  logic              w_last;
  logic              w_any_inv;
  logic [WAY_W-1:0]  w_hit_idx;
  logic [WAY_W-1:0]  w_inv_idx;
  logic [WAY_W-1:0]  w_new_victim;
  logic              w_victim_wb;

  assign w_req        = io_bus.mem_read ^ io_bus.mem_write;
  assign w_hit        = |io_bus.hit_way;
  assign w_multi      = |(io_bus.hit_way & (io_bus.hit_way - WAYS'(1)));
  assign w_last       = (r_beat == LAST_BEAT);
  assign w_any_inv    = ~&io_bus.valid_way;
  assign w_new_victim = w_any_inv ? w_inv_idx : io_bus.plru_victim;
  assign w_victim_wb  = io_bus.valid_way[w_new_victim] & io_bus.dirty_way[w_new_victim];

  // Lowest-index hit way and lowest-index invalid way (priority encoders).
  always_comb begin
    w_hit_idx = '0;
    w_inv_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (io_bus.hit_way[i])    w_hit_idx = WAY_W'(i);
      if (!io_bus.valid_way[i]) w_inv_idx = WAY_W'(i);
    end
  end

  // Main FSM: state, burst beat, latched victim, counters and sticky error.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_victim    <= '0;
      r_refill    <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_multi_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_refill <= 1'b0;
          if (w_req) r_state <= S_HIT_CHECK;
        end
        S_HIT_CHECK: begin
          if (w_multi) r_multi_err <= 1'b1;
          if (w_hit) begin
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            r_state <= S_IDLE;
          end else begin
            // a miss seen again after our own fill is not a new miss
            if (!r_refill && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            r_victim <= w_new_victim;
            if (NO_ALLOC && io_bus.mem_write) r_state <= S_WRITE_AROUND;
            else if (w_victim_wb)             r_state <= S_WRITE_BACK;
            else                              r_state <= S_ALLOCATE;
          end
        end
        S_WRITE_BACK: begin
          if (io_bus.pmem_resp) begin
            if (w_last) begin
              r_beat  <= '0;
              r_state <= S_ALLOCATE;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        S_ALLOCATE: begin
          if (io_bus.pmem_resp) begin
            if (w_last) begin
              r_beat   <= '0;
              r_refill <= 1'b1;
              r_state  <= S_HIT_CHECK;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        S_WRITE_AROUND: begin
          if (io_bus.pmem_resp) r_state <= S_IDLE;
        end
        default: begin
          r_beat  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from current state (plus hit vector / pmem_resp where the transfer needs it).
  always_comb begin
    io_bus.mem_resp    = 1'b0;
    io_bus.pmem_read   = 1'b0;
    io_bus.pmem_write  = 1'b0;
    io_bus.pmem_single = 1'b0;
    io_bus.pmem_beat   = '0;
    io_bus.way_sel     = '0;
    io_bus.addr_sel    = 1'b0;
    io_bus.load_data   = '0;
    io_bus.load_tag    = '0;
    io_bus.load_valid  = '0;
    io_bus.load_dirty  = '0;
    io_bus.dirty_in    = 1'b0;
    io_bus.load_plru   = 1'b0;
    case (r_state)
      S_HIT_CHECK: begin
        if (w_hit) begin
          io_bus.mem_resp  = 1'b1;
          io_bus.load_plru = 1'b1;
          io_bus.way_sel   = w_hit_idx;
          if (io_bus.mem_write) begin
            io_bus.load_data  = ONE_HOT0 << w_hit_idx;
            io_bus.load_dirty = ONE_HOT0 << w_hit_idx;
            io_bus.dirty_in   = 1'b1;
          end
        end
      end
      S_WRITE_BACK: begin
        io_bus.pmem_write = 1'b1;
        io_bus.addr_sel   = 1'b1;
        io_bus.way_sel    = r_victim;
        io_bus.pmem_beat  = r_beat;
      end
      S_ALLOCATE: begin
        io_bus.pmem_read = 1'b1;
        io_bus.way_sel   = r_victim;
        io_bus.pmem_beat = r_beat;
        if (io_bus.pmem_resp) begin
          io_bus.load_data = ONE_HOT0 << r_victim;
          if (w_last) begin
            io_bus.load_tag   = ONE_HOT0 << r_victim;
            io_bus.load_valid = ONE_HOT0 << r_victim;
            io_bus.load_dirty = ONE_HOT0 << r_victim;
          end
        end
      end
      S_WRITE_AROUND: begin
        io_bus.pmem_write  = 1'b1;
        io_bus.pmem_single = 1'b1;
        io_bus.mem_resp    = io_bus.pmem_resp;
      end
      default: ;
    endcase
  end

  assign io_bus.hit_count     = r_hit_cnt;
  assign io_bus.miss_count    = r_miss_cnt;
  assign io_bus.multi_hit_err = r_multi_err;
endmodule
